hazard_fwd_unit: RTL
====================

# hazard_fwd_unit

Parametrised hazard-detection and forwarding unit for the 5-stage pipeline. It evaluates the ID-stage instruction's source registers against the destinations in EX and MEM, and registers per-operand forwarding selects that take effect when the instruction enters EX. It also detects load-use hazards and drives a multi-cycle stall sequence sized by memory load latency. It sits between the decode stage and the ID/EX pipeline register.

## Interface
- REG_AW, 5: register-index width.
- NUM_SRC, 2: number of source operands per instruction (1..4).
- LOAD_LAT, 1: stall cycles inserted per load-use hazard (1..3).
- CNT_W, 16: statistics counter width (only with HAZ_STATS_EN).

- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID-stage instruction valid.
- id_src  in  NUM_SRC*REG_AW  source register indices; operand i at [i*REG_AW +: REG_AW].
- id_src_used  in  NUM_SRC  operand i is actually read.
- ex_valid, ex_regwrite, ex_is_load  in  1 each  EX-stage instruction attributes.
- ex_rd  in  REG_AW  EX-stage destination.
- mem_valid, mem_regwrite  in  1 each  MEM-stage instruction attributes.
- mem_rd  in  REG_AW  MEM-stage destination.
- fwd_sel  out  NUM_SRC*2  registered per-operand select: 00 regfile, 10 from EX/MEM, 01 from MEM/WB.
- stall  out  1  freeze PC and IF/ID; insert a bubble into ID/EX.
- stat_stall_cnt, stat_fwd_cnt  out  CNT_W each  present only with HAZ_STATS_EN.

## Operation
- A hazard match on operand i exists only when id_valid, id_src_used[i], and id_src[i] != 0 all hold.
- EX hit: ex_valid && ex_regwrite && ex_rd == id_src[i].
- MEM hit: mem_valid && mem_regwrite && mem_rd == id_src[i].
- Next select: EX hit gives 10. Otherwise MEM hit gives 01. Otherwise 00. The EX (younger) hit always wins.
- Load-use: an EX hit on any operand with ex_is_load set is a load-use hazard.
- FSM states: IDLE and STALL. Counter width is clog2(LOAD_LAT+1).
  - IDLE, load-use detected: stall=1 combinationally. If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1. Otherwise stay in IDLE.
  - STALL: stall=1 unconditionally. cnt decrements each cycle. At cnt==1, return to IDLE.
  - On the next IDLE cycle, hazards are re-evaluated against the current EX and MEM contents.
- fwd_sel update on each clock edge:
  - stall=1: load 00 on every operand, because a bubble enters EX.
  - Otherwise: load the computed next selects.
- No forwarding from WB. The register file is write-through, so a WB-stage writer needs no action here.
- Register 0 is never forwarded and never causes a stall.

## Timing
- Reset values: fwd_sel=0, stall=0, state=IDLE, cnt=0, stat counters=0.
- stall is gated by rst. Asserting reset mid-stall drops stall in the same cycle, and the FSM is in IDLE after release.
- Select latency is 1 cycle: the value computed in cycle N, with the instruction in ID, is valid in cycle N+1, with the instruction in EX.
- The stall is combinational from the inputs in IDLE and registered in STALL. Total stall per load-use hazard is exactly LOAD_LAT cycles.
- If a load-use hazard and a plain MEM hit coincide, the stall takes precedence and fwd_sel loads 00.
- When the same index is used on several operands, every matching operand gets the same select.

## Configuration
- HAZ_STATS_EN defined:
  - stat_stall_cnt increments on every cycle where stall=1.
  - stat_fwd_cnt increments by one on every edge where a nonzero select is loaded on any operand.
  - Both counters saturate at all-ones and clear on reset.
- HAZ_STATS_EN undefined: the stat ports and counters are absent, with no other change in behaviour.

## Structure
- Package hazard_pkg holds:
  - the fwd_sel_e enum: FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the hz_state_e enum: IDLE, STALL;
  - a LOAD_LAT_MAX=3 constant.
- Sub-module hazard_src_match is instantiated NUM_SRC times. It takes one source index, its used bit, and the EX/MEM attributes, and outputs next select plus a load-use flag.
- The top level ORs the load-use flags and holds the FSM, the select registers, and the stats logic.

## Test plan
- EX hit forward: id_src0=3, ex_rd=3, ex_regwrite=1, ex_is_load=0 -> stall=0; fwd_sel[1:0]=10 on the next cycle.
- Priority: id_src1=7, ex_rd=7 and mem_rd=7, both writing -> fwd_sel[3:2]=10, not 01.
- Load-use, LOAD_LAT=1: id_src0=5, ex_rd=5, ex_is_load=1 -> stall=1 for exactly 1 cycle and fwd_sel=00 next. The following cycle, with load in MEM (mem_rd=5), stall=0 and fwd_sel[1:0]=01.
- LOAD_LAT=3 load-use -> stall high for exactly 3 consecutive cycles. Asserting rst in the second stall cycle drops stall immediately, and after release the FSM is in IDLE with fwd_sel=0.
- Zero and masking: id_src0=0 with ex_rd=0 writing -> 00, no stall. id_src_used[1]=0 with a matching EX load -> no stall.
- HAZ_STATS_EN: two load-use hazards at LOAD_LAT=2 plus one forward -> stat_stall_cnt=4, stat_fwd_cnt=3 (counting the 01 selects after each stall). With CNT_W=2 and a continuous stall, the counter saturates at 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and limits for the hazard-detection / forwarding unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hz_state_e;

    localparam int unsigned LOAD_LAT_MAX = 3;

endpackage

// File: rtl/hazard_src_match.sv
// Per-operand comparison of one ID source register against the EX and MEM destinations.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] src_i,
    input  logic              used_i,
    input  logic              ex_valid_i,
    input  logic              ex_regwrite_i,
    input  logic              ex_is_load_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              mem_valid_i,
    input  logic              mem_regwrite_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    output fwd_sel_e          sel_o,
    output logic              load_use_o
);

    logic active;
    logic ex_hit;
    logic mem_hit;

    // r0 is hardwired zero, so it never matches anything
    assign active  = id_valid_i && used_i && (src_i != '0);
    assign ex_hit  = active && ex_valid_i && ex_regwrite_i && (ex_rd_i == src_i);
    assign mem_hit = active && mem_valid_i && mem_regwrite_i && (mem_rd_i == src_i);

    always_comb begin
        sel_o = FWD_NONE;
        if (ex_hit) begin
            sel_o = FWD_MEM;
        end else if (mem_hit) begin
            sel_o = FWD_WB;
        end
    end

    assign load_use_o = ex_hit && ex_is_load_i;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding-select unit between decode and the ID/EX register.
// Optional statistics counters are built when HAZ_STATS_EN is defined.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_i,
    input  logic [NUM_SRC-1:0]        id_src_used_i,
    input  logic                      ex_valid_i,
    input  logic                      ex_regwrite_i,
    input  logic                      ex_is_load_i,
    input  logic [REG_AW-1:0]         ex_rd_i,
    input  logic                      mem_valid_i,
    input  logic                      mem_regwrite_i,
    input  logic [REG_AW-1:0]         mem_rd_i,
    output logic [NUM_SRC*2-1:0]      fwd_sel_o,
    output logic                      stall_o
`ifdef HAZ_STATS_EN
    ,
    output logic [CNT_W-1:0]          stat_stall_cnt_o,
    output logic [CNT_W-1:0]          stat_fwd_cnt_o
`endif
);

    localparam int unsigned CNT_BITS = $clog2(LOAD_LAT + 1);

    if (NUM_SRC < 1 || NUM_SRC > 4 || LOAD_LAT < 1 || LOAD_LAT > LOAD_LAT_MAX || CNT_W < 1) begin : g_bad_param
        $error("hazard_fwd_unit: parameter out of range");
    end

    logic [NUM_SRC*2-1:0] sel_nxt;
    logic [NUM_SRC-1:0]   lu_vec;
    logic                 load_use;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_src_match #(
            .REG_AW (REG_AW)
        ) u_match (
            .id_valid_i     (id_valid_i),
            .src_i          (id_src_i[i*REG_AW +: REG_AW]),
            .used_i         (id_src_used_i[i]),
            .ex_valid_i     (ex_valid_i),
            .ex_regwrite_i  (ex_regwrite_i),
            .ex_is_load_i   (ex_is_load_i),
            .ex_rd_i        (ex_rd_i),
            .mem_valid_i    (mem_valid_i),
            .mem_regwrite_i (mem_regwrite_i),
            .mem_rd_i       (mem_rd_i),
            .sel_o          (sel_nxt[2*i +: 2]),
            .load_use_o     (lu_vec[i])
        );
    end

    assign load_use = |lu_vec;

    hz_state_e           state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // First stall cycle is spent in IDLE, so STALL covers the remaining LOAD_LAT-1
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (load_use && (LOAD_LAT > 1)) begin
                    state_d = STALL;
                    cnt_d   = CNT_BITS'(LOAD_LAT - 1);
                end
            end
            STALL: begin
                cnt_d = cnt_q - CNT_BITS'(1);
                if (cnt_q == CNT_BITS'(1)) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        stall_o = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE:  stall_o = load_use;
                STALL: stall_o = 1'b1;
            endcase
        end
    end

    logic [NUM_SRC*2-1:0] fwd_sel_q, fwd_sel_d;

    // A stalled cycle pushes a bubble into EX, which must not forward
    assign fwd_sel_d = stall_o ? '0 : sel_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_sel_q <= '0;
        end else begin
            fwd_sel_q <= fwd_sel_d;
        end
    end

    assign fwd_sel_o = fwd_sel_q;

`ifdef HAZ_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, fwd_cnt_q;
    logic             fwd_load;

    assign fwd_load = (fwd_sel_d != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (fwd_load && (fwd_cnt_q != '1)) begin
                fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stat_stall_cnt_o = stall_cnt_q;
    assign stat_fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule
